// File: rtl/dom_and_pipe.sv
// Domain-oriented-masking AND gadget of arbitrary order and lane count.
// Cross-domain products are reshared into a register stage, then compressed into registered output shares.
module dom_and_pipe #(
  parameter int ORDER = 1,
  parameter int WIDTH = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic [(ORDER+1)*WIDTH-1:0]           a_sh,
  input  logic [(ORDER+1)*WIDTH-1:0]           b_sh,
  input  logic [(ORDER*(ORDER+1)/2)*WIDTH-1:0] rnd,
  output logic                                 out_valid,
  output logic [(ORDER+1)*WIDTH-1:0]           out_sh
);

  localparam int N  = ORDER + 1;
  localparam int NR = ORDER * (ORDER + 1) / 2;

  // Lexicographic index of the unordered share pair {i,j}; both c_ij and c_ji use the same mask.
  function automatic int pair_idx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * ORDER - (lo * (lo - 1)) / 2 + (hi - lo - 1);
  endfunction

  logic [N*N*WIDTH-1:0] c_p0;
  logic [N*N*WIDTH-1:0] c_p1;
  logic                 vld_p1;
  logic [N*WIDTH-1:0]   sh_p1;
  logic [N*WIDTH-1:0]   sh_p2;
  logic                 vld_p2;

  always_comb begin
    c_p0 = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        c_p0[(i*N+j)*WIDTH +: WIDTH] = a_sh[i*WIDTH +: WIDTH] & b_sh[j*WIDTH +: WIDTH];
        if (i != j) begin
          c_p0[(i*N+j)*WIDTH +: WIDTH] = c_p0[(i*N+j)*WIDTH +: WIDTH]
                                         ^ rnd[pair_idx(i, j)*WIDTH +: WIDTH];
        end
      end
    end
  end

  // ---- stage 1: resharing registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      c_p1   <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        c_p1 <= c_p0;
      end
    end
  end

  always_comb begin
    sh_p1 = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sh_p1[i*WIDTH +: WIDTH] = sh_p1[i*WIDTH +: WIDTH] ^ c_p1[(i*N+j)*WIDTH +: WIDTH];
      end
    end
  end

  // ---- stage 2: compressed output shares ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      sh_p2  <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        sh_p2 <= sh_p1;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_sh    = sh_p2;

endmodule

// File: tb/tb_dom_and_pipe.sv
// Bench for dom_and_pipe: three configurations checked against an unmasked scoreboard,
// a cycle-exact valid model, and hand-computed first-order share values.
module tb_dom_and_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // ORDER=1, WIDTH=1
  logic        iv1 = 1'b0, ov1;
  logic [1:0]  a1 = '0, b1 = '0, o1;
  logic [0:0]  r1 = '0;
  // ORDER=2, WIDTH=8
  logic        iv2 = 1'b0, ov2;
  logic [23:0] a2 = '0, b2 = '0, r2 = '0, o2;
  // ORDER=3, WIDTH=4
  logic        iv3 = 1'b0, ov3;
  logic [15:0] a3 = '0, b3 = '0, o3;
  logic [23:0] r3 = '0;

  dom_and_pipe #(.ORDER(1), .WIDTH(1)) u1 (.clk(clk), .rst(rst), .in_valid(iv1), .a_sh(a1),
    .b_sh(b1), .rnd(r1), .out_valid(ov1), .out_sh(o1));
  dom_and_pipe #(.ORDER(2), .WIDTH(8)) u2 (.clk(clk), .rst(rst), .in_valid(iv2), .a_sh(a2),
    .b_sh(b2), .rnd(r2), .out_valid(ov2), .out_sh(o2));
  dom_and_pipe #(.ORDER(3), .WIDTH(4)) u3 (.clk(clk), .rst(rst), .in_valid(iv3), .a_sh(a3),
    .b_sh(b3), .rnd(r3), .out_valid(ov3), .out_sh(o3));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] unm(input logic [63:0] v, input int n, input int w);
    logic [63:0] m;
    logic [7:0]  r;
    m = (64'd1 << w) - 64'd1;
    r = '0;
    for (int i = 0; i < n; i++) r = r ^ 8'((v >> (i * w)) & m);
    return r;
  endfunction

  logic [7:0] q1[$], q2[$], q3[$];
  int n2_in = 0, n2_out = 0;

  // Expected out_valid: in_valid two edges back with no reset on either edge.
  logic m1a = 1'b0, m1b = 1'b0, m2a = 1'b0, m2b = 1'b0, m3a = 1'b0, m3b = 1'b0;
  always @(posedge clk) begin
    m1a <= rst ? 1'b0 : iv1;  m1b <= rst ? 1'b0 : m1a;
    m2a <= rst ? 1'b0 : iv2;  m2b <= rst ? 1'b0 : m2a;
    m3a <= rst ? 1'b0 : iv3;  m3b <= rst ? 1'b0 : m3a;
    if (rst) begin
      q1.delete(); q2.delete(); q3.delete();
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("u1_valid", 64'(ov1), 64'(m1b));
      chk("u2_valid", 64'(ov2), 64'(m2b));
      chk("u3_valid", 64'(ov3), 64'(m3b));
      if (ov1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL u1_extra: out_valid with empty scoreboard at %0t", $time);
        end else chk("u1_data", 64'(unm(64'(o1), 2, 1)), 64'(q1.pop_front()));
      end
      if (ov2) begin
        n2_out++;
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL u2_extra: out_valid with empty scoreboard at %0t", $time);
        end else chk("u2_data", 64'(unm(64'(o2), 3, 8)), 64'(q2.pop_front()));
      end
      if (ov3) begin
        if (q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL u3_extra: out_valid with empty scoreboard at %0t", $time);
        end else chk("u3_data", 64'(unm(64'(o3), 4, 4)), 64'(q3.pop_front()));
      end
    end
  end

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [0:0] r;
    logic [1:0] o;
  } vec_t;
  vec_t tbl[6];

  task automatic drive1(input logic [1:0] a, input logic [1:0] b, input logic [0:0] r);
    a1 = a; b1 = b; r1 = r; iv1 = 1'b1;
    q1.push_back(8'((a[0] ^ a[1]) & (b[0] ^ b[1])));
  endtask

  initial begin
    // out0 = a0b0 ^ a0b1 ^ r ; out1 = a1b0 ^ r ^ a1b1
    tbl[0] = '{a: 2'b01, b: 2'b10, r: 1'b1, o: 2'b10};
    tbl[1] = '{a: 2'b11, b: 2'b11, r: 1'b0, o: 2'b00};
    tbl[2] = '{a: 2'b01, b: 2'b01, r: 1'b0, o: 2'b01};
    tbl[3] = '{a: 2'b10, b: 2'b11, r: 1'b1, o: 2'b11};
    tbl[4] = '{a: 2'b11, b: 2'b01, r: 1'b1, o: 2'b00};
    tbl[5] = '{a: 2'b01, b: 2'b11, r: 1'b1, o: 2'b11};

    repeat (3) @(negedge clk);
    chk("rst_ov1", 64'(ov1), 64'd0);  chk("rst_o1", 64'(o1), 64'd0);
    chk("rst_ov2", 64'(ov2), 64'd0);  chk("rst_o2", 64'(o2), 64'd0);
    chk("rst_ov3", 64'(ov3), 64'd0);  chk("rst_o3", 64'(o3), 64'd0);
    rst = 1'b0;
    armed = 1'b1;

    // Single pulses with exact share values and exact latency.
    foreach (tbl[k]) begin
      @(negedge clk); drive1(tbl[k].a, tbl[k].b, tbl[k].r);
      @(negedge clk); iv1 = 1'b0; a1 = 2'($urandom); b1 = 2'($urandom);
      chk("tbl_early", 64'(ov1), 64'd0);
      @(negedge clk);
      chk("tbl_valid", 64'(ov1), 64'd1);
      chk("tbl_shares", 64'(o1), 64'(tbl[k].o));
      @(negedge clk);
      chk("tbl_late", 64'(ov1), 64'd0);
    end

    // Idle with noisy inputs: shares must hold the last result.
    repeat (5) begin
      @(negedge clk); a1 = 2'($urandom); b1 = 2'($urandom); r1 = 1'($urandom);
    end
    chk("u1_hold", 64'(o1), 64'(tbl[5].o));

    // Exhaustive first-order stream, back-to-back.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); drive1(2'(i), 2'(i >> 2), 1'(i >> 4));
    end
    @(negedge clk); iv1 = 1'b0;
    repeat (3) @(negedge clk);

    // Second order, 8 lanes, random gaps.
    for (int n = 0; n < 1000; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); iv2 = 1'b0;
        a2 = 24'($urandom); b2 = 24'($urandom); r2 = 24'($urandom);
      end
      @(negedge clk);
      a2 = 24'($urandom); b2 = 24'($urandom); r2 = 24'($urandom); iv2 = 1'b1;
      q2.push_back(unm(64'(a2), 3, 8) & unm(64'(b2), 3, 8));
      n2_in++;
    end
    @(negedge clk); iv2 = 1'b0;
    repeat (3) @(negedge clk);

    // Third order, 4 lanes, zero randomness, a=F b=A.
    for (int n = 0; n < 4; n++) begin
      logic [11:0] xa, xb;
      @(negedge clk);
      xa = 12'($urandom); xb = 12'($urandom);
      a3 = {4'hF ^ xa[3:0] ^ xa[7:4] ^ xa[11:8], xa};
      b3 = {4'hA ^ xb[3:0] ^ xb[7:4] ^ xb[11:8], xb};
      r3 = '0; iv3 = 1'b1;
      q3.push_back(8'h0A);
    end
    @(negedge clk); iv3 = 1'b0;
    repeat (3) @(negedge clk);
    repeat (6) begin
      @(negedge clk); a3 = 16'($urandom); b3 = 16'($urandom); r3 = 24'($urandom);
    end
    chk("u3_hold_val", 64'(unm(64'(o3), 4, 4)), 64'h0A);
    chk("u3_hold_ov", 64'(ov3), 64'd0);

    // Reset mid-stream: ops at t and t+1 discarded, fresh op right after reset.
    @(negedge clk); drive1(tbl[0].a, tbl[0].b, tbl[0].r);
    @(negedge clk); drive1(tbl[5].a, tbl[5].b, tbl[5].r); rst = 1'b1;
    @(negedge clk); iv1 = 1'b0;
    chk("rst_mid_ov", 64'(ov1), 64'd0);  chk("rst_mid_o", 64'(o1), 64'd0);
    @(negedge clk);
    chk("rst_hold_ov", 64'(ov1), 64'd0); chk("rst_hold_o", 64'(o1), 64'd0);
    rst = 1'b0; drive1(tbl[3].a, tbl[3].b, tbl[3].r);
    @(negedge clk); iv1 = 1'b0;
    chk("post_rst_early", 64'(ov1), 64'd0);
    @(negedge clk);
    chk("post_rst_valid", 64'(ov1), 64'd1);
    chk("post_rst_shares", 64'(o1), 64'(tbl[3].o));
    repeat (3) @(negedge clk);

    chk("u1_drained", 64'(q1.size()), 64'd0);
    chk("u2_drained", 64'(q2.size()), 64'd0);
    chk("u3_drained", 64'(q3.size()), 64'd0);
    chk("u2_count", 64'(n2_out), 64'(n2_in));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
